ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit length in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles between device clock falling edges (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tx_valid  input  1  command byte request.
REQ-006 SHALL have port tx_data  input  8  command byte, sampled on accept.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have port ps2_clk_in  input  1  PS/2 CLK pin level, asynchronous.
REQ-009 SHALL have port ps2_dat_in  input  1  PS/2 DAT pin level, asynchronous.
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = drive CLK low; 0 = release (open-drain, pad outside block).
REQ-011 SHALL have port ps2_dat_oe  output  1  1 = drive DAT low; 0 = release.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse, byte sent and acknowledged.
REQ-013 SHALL have port tx_error  output  1  one-cycle pulse, no ack or timeout.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_dat_in through 2-flop synchronizers; falling edge = previous synced CLK 1, current synced CLK 0.
REQ-015 SHALL accept a byte when tx_valid & tx_ready on a clk edge; tx_data and odd parity (~^tx_data) latched; tx_ready low from the next cycle.
REQ-016 SHALL ignore tx_valid while tx_ready is low; no queueing.
REQ-017 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-018 IDLE: clk_oe=0, dat_oe=0, tx_ready=1; accept -> INHIBIT.
REQ-019 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
REQ-020 REQ: clk_oe=1, dat_oe=1 (start bit) for one cycle -> SHIFT; bit counter cleared, timeout counter cleared.
REQ-021 SHIFT: clk_oe=0; dat_oe=1 held until first falling edge; on falling edge n (n=1..8) dat_oe=~data[n-1] (LSB first), n=9 dat_oe=~parity, n=10 dat_oe=0 (stop); after edge 10 -> ACK.
REQ-022 dat_oe SHALL update in the cycle after the falling edge is detected; latency pin-to-dat_oe at most 4 clk cycles.
REQ-023 ACK: dat_oe=0; on falling edge 11 sample synced DAT: 0 -> WAIT_IDLE; 1 -> tx_error pulse, IDLE.
REQ-024 WAIT_IDLE: when synced CLK=1 and DAT=1 -> tx_done pulse, IDLE.
REQ-025 Timeout counter SHALL clear on each falling edge and in REQ; reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE -> release both lines, tx_error pulse, IDLE.
REQ-026 tx_done and tx_error SHALL never assert in the same cycle; each exactly one cycle per transfer, exactly one of them per accepted byte.
REQ-027 Falling edges outside SHIFT/ACK (device-initiated traffic in IDLE) SHALL be ignored; the block never drives lines in IDLE.
REQ-028 Bit counter 4 bits, saturating; no falling edge beyond 11 processed per transfer.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, clk_oe=0, dat_oe=0, tx_done=0, tx_error=0, tx_ready=1 after release, counters and synchronizers cleared (synchronizers to 1).
REQ-030 Reset asserted mid-transfer SHALL release both lines asynchronously and produce no tx_done/tx_error pulse.

Verification
REQ-031 Send 0xED, device model clocks 11 edges, acks -> DAT bits 1,0,1,1,0,1,1,1, parity 1, stop 1, tx_done one pulse, tx_ready back high.
REQ-032 Send 0x00 -> eight 0 bits, parity 1; clk_oe high exactly 5000 cycles before dat_oe rises.
REQ-033 Device holds DAT high on edge 11 -> tx_error one pulse, tx_done never, both oe low.
REQ-034 Device stops clocking after edge 4 -> tx_error exactly TIMEOUT_CYCLES after edge 4 detection, lines released.
REQ-035 reset_n low during SHIFT after edge 6 -> clk_oe=dat_oe=0 same cycle, no pulses; next 0xF4 transfer completes normally.
REQ-036 tx_valid held high with 0xFF during transfer of 0xAB -> only 0xAB sent; 0xFF accepted only after return to IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte plus odd parity on device clock falling edges and checks the device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic          r_clkMeta;
  logic          r_clkSync;
  logic          r_clkPrev;
  logic          r_datMeta;
  logic          r_datSync;
  logic [7:0]    r_data;
  logic          r_parity;
  logic [3:0]    r_bitCnt;
  logic [IW-1:0] r_inhCnt;
  logic [TW-1:0] r_toCnt;
  logic          r_clkOe;
  logic          r_datOe;
  logic          r_ready;
  logic          r_txDone;
  logic          r_txError;

  logic          w_fall;
  logic          w_timeout;

  // Idle bus level is high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkMeta <= 1'b1;
      r_clkSync <= 1'b1;
      r_clkPrev <= 1'b1;
      r_datMeta <= 1'b1;
      r_datSync <= 1'b1;
    end else begin
      r_clkMeta <= ps2_clk_in;
      r_clkSync <= r_clkMeta;
      r_clkPrev <= r_clkSync;
      r_datMeta <= ps2_dat_in;
      r_datSync <= r_datMeta;
    end
  end

  assign w_fall    = r_clkPrev & ~r_clkSync;
  assign w_timeout = (r_toCnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_data    <= 8'h00;
      r_parity  <= 1'b0;
      r_bitCnt  <= 4'd0;
      r_inhCnt  <= '0;
      r_toCnt   <= '0;
      r_clkOe   <= 1'b0;
      r_datOe   <= 1'b0;
      r_ready   <= 1'b1;
      r_txDone  <= 1'b0;
      r_txError <= 1'b0;
    end else begin
      r_txDone  <= 1'b0;
      r_txError <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clkOe <= 1'b0;
          r_datOe <= 1'b0;
          r_ready <= 1'b1;
          if (tx_valid) begin
            r_data   <= tx_data;
            r_parity <= ~^tx_data;
            r_inhCnt <= '0;
            r_clkOe  <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inhCnt == INH_LAST) begin
            r_datOe <= 1'b1;
            r_state <= REQ;
          end else begin
            r_inhCnt <= r_inhCnt + 1'b1;
          end
        end
        REQ: begin
          r_clkOe  <= 1'b0;
          r_bitCnt <= 4'd0;
          r_toCnt  <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          if (w_fall) begin
            r_toCnt <= '0;
            if (r_bitCnt != 4'hF) r_bitCnt <= r_bitCnt + 4'd1;
            // Edges 1..8 carry data LSB first, edge 9 parity, edge 10 releases for stop.
            if (r_bitCnt < 4'd8) begin
              r_datOe <= ~r_data[r_bitCnt[2:0]];
            end else if (r_bitCnt == 4'd8) begin
              r_datOe <= ~r_parity;
            end else begin
              r_datOe <= 1'b0;
              r_state <= ACK;
            end
          end else if (w_timeout) begin
            r_clkOe   <= 1'b0;
            r_datOe   <= 1'b0;
            r_txError <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        ACK: begin
          r_datOe <= 1'b0;
          if (w_fall) begin
            r_toCnt <= '0;
            if (r_bitCnt != 4'hF) r_bitCnt <= r_bitCnt + 4'd1;
            if (!r_datSync) begin
              r_state <= WAIT_IDLE;
            end else begin
              r_txError <= 1'b1;
              r_ready   <= 1'b1;
              r_state   <= IDLE;
            end
          end else if (w_timeout) begin
            r_clkOe   <= 1'b0;
            r_txError <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (r_clkSync && r_datSync) begin
            r_txDone <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= IDLE;
          end else if (w_timeout) begin
            r_clkOe   <= 1'b0;
            r_datOe   <= 1'b0;
            r_txError <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end else if (w_fall) begin
            r_toCnt <= '0;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        default: begin
          r_clkOe <= 1'b0;
          r_datOe <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = r_ready;
  assign ps2_clk_oe = r_clkOe;
  assign ps2_dat_oe = r_datOe;
  assign tx_done    = r_txDone;
  assign tx_error   = r_txError;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// and the captured bits, timing and pulses are compared against a frame model.
module tb_ps2_host_tx;

  localparam int INH  = 1000;
  localparam int TMO  = 600;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       tx_done;
  logic       tx_error;
  logic       devClk = 1'b1;
  logic       devDat = 1'b1;
  logic       clkPin;
  logic       datPin;

  int vectors = 0;
  int miscompares = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;

  // Open-drain bus: pulled high, low whenever either side drives it.
  assign clkPin = devClk & ~ps2_clk_oe;
  assign datPin = devDat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ps2_clk_in(clkPin),
    .ps2_dat_in(datPin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  // Counts every cycle a pulse output is high, so a stretched pulse shows up as an extra count.
  always @(posedge clk) begin
    #1;
    if (tx_done === 1'b1) doneCnt++;
    if (tx_error === 1'b1) errCnt++;
    if (tx_done === 1'b1 && tx_error === 1'b1) bothCnt++;
  end

  initial begin
    #(2000000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected wire levels sampled by the device: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] frameOf(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((b >> i) & 8'd1) != 8'd0;
      if (f[i]) ones++;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic deviceBit(output logic early, output logic late);
    devClk = 1'b0;
    repeat (4) @(negedge clk);
    early = datPin;
    repeat (HALF - 4) @(negedge clk);
    devClk = 1'b1;
    late = datPin;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic runToShift();
    int cnt;
    cnt = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && cnt < INH + 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= INH + 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL reach_shift: got no request after %0d cycles want request", cnt);
    end
    repeat (4) @(negedge clk);
  endtask

  // Entered on the falling edge right after the byte was accepted.
  task automatic serviceTransfer(input logic [7:0] b, input logic ack, input string tag);
    logic [9:0] exp;
    logic [9:0] seenEarly;
    logic [9:0] seenLate;
    logic       early;
    logic       late;
    logic       clkOk;
    int         cnt;
    int         d0;
    int         e0;
    int         b0;
    d0 = doneCnt;
    e0 = errCnt;
    b0 = bothCnt;
    exp = frameOf(b);
    seenEarly = '0;
    seenLate = '0;

    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s ready_low: got %b want 0", tag, tx_ready);
    end

    cnt = 0;
    clkOk = 1'b1;
    while (ps2_dat_oe !== 1'b1 && cnt < INH + 100) begin
      if (ps2_clk_oe !== 1'b1) clkOk = 1'b0;
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != INH || !clkOk) begin
      miscompares++;
      $display("[TB] FAIL %s inhibit: got %0d cycles (clk held %b) want %0d (1)", tag, cnt, clkOk, INH);
    end

    vectors++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL %s req_phase: got %b want 11", tag, {ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL %s shift_entry: got %b want 01", tag, {ps2_clk_oe, ps2_dat_oe});
    end

    repeat (4) @(negedge clk);
    vectors++;
    if ({clkPin, datPin} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL %s start_bit: got clk/dat %b want 10", tag, {clkPin, datPin});
    end

    for (int i = 0; i < 10; i++) begin
      deviceBit(early, late);
      seenEarly[i] = early;
      seenLate[i] = late;
    end
    vectors++;
    if (seenLate !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s frame: got %b want %b", tag, seenLate, exp);
    end
    vectors++;
    if (seenEarly !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %b want %b", tag, seenEarly, exp);
    end

    devDat = ack ? 1'b0 : 1'b1;
    repeat (2) @(negedge clk);
    devClk = 1'b0;
    repeat (HALF) @(negedge clk);
    devClk = 1'b1;
    devDat = 1'b1;

    cnt = 0;
    while (tx_ready !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (cnt >= 200) begin
      miscompares++;
      $display("[TB] FAIL %s ready_return: got %b want 1", tag, tx_ready);
    end
    vectors++;
    if ((doneCnt - d0) != (ack ? 1 : 0) || (errCnt - e0) != (ack ? 0 : 1) || bothCnt != b0) begin
      miscompares++;
      $display("[TB] FAIL %s pulses: got done %0d err %0d both %0d want done %0d err %0d both 0",
               tag, doneCnt - d0, errCnt - e0, bothCnt - b0, ack ? 1 : 0, ack ? 0 : 1);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL %s released: got %b want 00", tag, {ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic applyByte(input logic [7:0] b);
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL idle_ready: got %b want 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic test_send(input logic [7:0] b, input logic ack, input string tag);
    applyByte(b);
    serviceTransfer(b, ack, tag);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b want 10000",
               {tx_ready, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({tx_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL post_reset: got %b want 100", {tx_ready, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_idle_traffic();
    logic quiet;
    int   d0;
    int   e0;
    quiet = 1'b1;
    d0 = doneCnt;
    e0 = errCnt;
    for (int i = 0; i < 12; i++) begin
      devDat = 1'($urandom_range(0, 1));
      devClk = 1'b0;
      repeat (HALF) begin
        @(negedge clk);
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) quiet = 1'b0;
      end
      devClk = 1'b1;
      repeat (HALF) begin
        @(negedge clk);
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) quiet = 1'b0;
      end
    end
    devDat = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (!quiet || doneCnt != d0 || errCnt != e0) begin
      miscompares++;
      $display("[TB] FAIL idle_traffic: got quiet %b pulses %0d want quiet 1 pulses 0",
               quiet, (doneCnt - d0) + (errCnt - e0));
    end
  endtask

  task automatic test_timeout();
    logic early;
    logic late;
    int   cnt;
    int   d0;
    int   e0;
    applyByte(8'($urandom_range(0, 255)));
    runToShift();
    d0 = doneCnt;
    e0 = errCnt;
    for (int i = 0; i < 3; i++) deviceBit(early, late);
    devClk = 1'b0;
    cnt = 0;
    while (tx_error !== 1'b1 && cnt < TMO + 50) begin
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (cnt != TMO + 3) begin
      miscompares++;
      $display("[TB] FAIL timeout_delay: got %0d cycles want %0d", cnt, TMO + 3);
    end
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001 || (errCnt - e0) != 1 || doneCnt != d0) begin
      miscompares++;
      $display("[TB] FAIL timeout_state: got oe/ready %b err %0d done %0d want 001 err 1 done 0",
               {ps2_clk_oe, ps2_dat_oe, tx_ready}, errCnt - e0, doneCnt - d0);
    end
    devClk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic early;
    logic late;
    int   d0;
    int   e0;
    applyByte(8'h00);
    runToShift();
    d0 = doneCnt;
    e0 = errCnt;
    for (int i = 0; i < 6; i++) deviceBit(early, late);
    devClk = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (ps2_dat_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_drive: got dat_oe %b want 1", ps2_dat_oe);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL async_release: got oe/ready %b want 001", {ps2_clk_oe, ps2_dat_oe, tx_ready});
    end
    devClk = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (doneCnt != d0 || errCnt != e0) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses: got done %0d err %0d want 0 0", doneCnt - d0, errCnt - e0);
    end
    test_send(8'hF4, 1'b1, "F4");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hAB;
    @(negedge clk);
    tx_data = 8'hFF;
    serviceTransfer(8'hAB, 1'b1, "AB");
    @(negedge clk);
    tx_valid = 1'b0;
    serviceTransfer(8'hFF, 1'b1, "FF");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       ack;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      test_send(b, ack, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_idle_traffic();
    test_send(8'hED, 1'b1, "ED");
    test_send(8'h00, 1'b1, "00");
    test_send(8'h3C, 1'b0, "nack");
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
